// File: rtl/axi_shim_mo_if.sv
// AXI4+ATOP master-side channel bundle used by axi_shim_mo.
// A beat transfers on a rising clk_i edge where valid and ready are both high; the source holds valid and payload stable until that edge.
interface axi_shim_mo_if #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiUserWidth = 1
);
  logic [AxiIdWidth-1:0]     aw_id;
  logic [AxiAddrWidth-1:0]   aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AxiDataWidth-1:0]   w_data;
  logic [AxiDataWidth/8-1:0] w_strb;
  logic                      w_last;
  logic [AxiUserWidth-1:0]   w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AxiIdWidth-1:0]     b_id;
  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AxiIdWidth-1:0]     ar_id;
  logic [AxiAddrWidth-1:0]   ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AxiIdWidth-1:0]     r_id;
  logic [AxiDataWidth-1:0]   r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AxiUserWidth-1:0]   r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_shim_mo.sv
// AXI4 master shim: req/gnt cache/PTW ports to AXI with decoupled AW/W and outstanding limits.
// Optional stall counters are built when AXI_SHIM_MO_PERF_CNT_EN is defined.
module axi_shim_mo #(
  parameter int unsigned AxiDataWidth     = 64,
  parameter int unsigned AxiAddrWidth     = 64,
  parameter int unsigned AxiIdWidth       = 4,
  parameter int unsigned AxiUserWidth     = 1,
  parameter int unsigned AxiNumWords      = 4,
  parameter int unsigned MaxWrOutstanding = 4,
  parameter int unsigned MaxRdOutstanding = 4,
  localparam int unsigned BlenW = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           rd_req_i,
  output logic                                           rd_gnt_o,
  input  logic [AxiAddrWidth-1:0]                        rd_addr_i,
  input  logic [BlenW-1:0]                               rd_blen_i,
  input  logic [2:0]                                     rd_size_i,
  input  logic [AxiIdWidth-1:0]                          rd_id_i,
  input  logic                                           rd_lock_i,
  input  logic                                           rd_rdy_i,
  output logic                                           rd_valid_o,
  output logic                                           rd_last_o,
  output logic [AxiDataWidth-1:0]                        rd_data_o,
  output logic [AxiUserWidth-1:0]                        rd_user_o,
  output logic [AxiIdWidth-1:0]                          rd_id_o,
  output logic                                           rd_exokay_o,
  input  logic                                           wr_req_i,
  output logic                                           wr_gnt_o,
  input  logic [AxiAddrWidth-1:0]                        wr_addr_i,
  input  logic [AxiNumWords-1:0][AxiDataWidth-1:0]       wr_data_i,
  input  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0]     wr_be_i,
  input  logic [AxiNumWords-1:0][AxiUserWidth-1:0]       wr_user_i,
  input  logic [BlenW-1:0]                               wr_blen_i,
  input  logic [2:0]                                     wr_size_i,
  input  logic [AxiIdWidth-1:0]                          wr_id_i,
  input  logic                                           wr_lock_i,
  input  logic [5:0]                                     wr_atop_i,
  input  logic                                           wr_rdy_i,
  output logic                                           wr_valid_o,
  output logic [AxiIdWidth-1:0]                          wr_id_o,
  output logic                                           wr_exokay_o,
  output logic                                           wr_busy_o,
  output logic                                           rd_busy_o,
  output logic                                           wr_state_o,
  axi_shim_mo_if.master                                  axi
`ifdef AXI_SHIM_MO_PERF_CNT_EN
  ,
  input  logic                                           perf_clr_i,
  output logic [31:0]                                    wr_stall_cnt_o,
  output logic [31:0]                                    rd_stall_cnt_o
`endif
);
  localparam int unsigned WrCntW = $clog2(MaxWrOutstanding + 1);
  localparam int unsigned RdCntW = $clog2(MaxRdOutstanding + 1);

  typedef enum logic {WR_IDLE = 1'b0, WR_ACTIVE = 1'b1} wr_state_e;

  wr_state_e         state_q, state_d;
  logic [BlenW-1:0]  cnt_q;
  logic              aw_done_q, w_done_q;
  logic [WrCntW-1:0] wr_out_q;
  logic [RdCntW-1:0] rd_out_q;
  logic              wr_active, aw_hs, w_hs, b_hs, r_last_hs;

  assign wr_busy_o  = (wr_out_q == WrCntW'(MaxWrOutstanding));
  assign rd_busy_o  = (rd_out_q == RdCntW'(MaxRdOutstanding));
  assign wr_state_o = state_q;

  assign aw_hs     = axi.aw_valid && axi.aw_ready;
  assign w_hs      = axi.w_valid && axi.w_ready;
  assign b_hs      = axi.b_valid && axi.b_ready;
  assign r_last_hs = axi.r_valid && axi.r_ready && axi.r_last;

  // Write FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= WR_IDLE;
    else         state_q <= state_d;
  end

  // Write FSM: next state. A granted write always lands back in IDLE.
  always_comb begin
    state_d = state_q;
    if (wr_gnt_o)       state_d = WR_IDLE;
    else if (wr_active) state_d = WR_ACTIVE;
  end

  // Write FSM: outputs. The IDLE->ACTIVE decision drives both valids in the same cycle;
  // rst_ni holds every valid low while reset is asserted.
  always_comb begin
    wr_active    = rst_ni && ((state_q == WR_ACTIVE) || (wr_req_i && !wr_busy_o));
    axi.aw_valid = wr_active && !aw_done_q;
    axi.w_valid  = wr_active && !w_done_q;
    axi.w_last   = (cnt_q == wr_blen_i);
    wr_gnt_o     = wr_active && (aw_done_q || axi.aw_ready)
                             && (w_done_q || (axi.w_ready && axi.w_last));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (wr_gnt_o) begin
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs) begin
        if (axi.w_last) w_done_q <= 1'b1;
        else            cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  // Outstanding counters: simultaneous increment and decrement cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_out_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (wr_gnt_o && !b_hs)      wr_out_q <= wr_out_q + 1'b1;
      else if (!wr_gnt_o && b_hs) wr_out_q <= wr_out_q - 1'b1;
      if (rd_gnt_o && !r_last_hs)      rd_out_q <= rd_out_q + 1'b1;
      else if (!rd_gnt_o && r_last_hs) rd_out_q <= rd_out_q - 1'b1;
    end
  end

  assign axi.aw_id     = wr_id_i;
  assign axi.aw_addr   = wr_addr_i;
  assign axi.aw_len    = 8'(wr_blen_i);
  assign axi.aw_size   = wr_size_i;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = wr_lock_i;
  assign axi.aw_cache  = 4'b0010;
  assign axi.aw_prot   = 3'b000;
  assign axi.aw_qos    = 4'b0000;
  assign axi.aw_region = 4'b0000;
  assign axi.aw_atop   = wr_atop_i;
  assign axi.w_data    = wr_data_i[cnt_q];
  assign axi.w_strb    = wr_be_i[cnt_q];
  assign axi.w_user    = wr_user_i[cnt_q];

  assign axi.ar_valid  = rst_ni && rd_req_i && !rd_busy_o;
  assign rd_gnt_o      = axi.ar_valid && axi.ar_ready;
  assign axi.ar_id     = rd_id_i;
  assign axi.ar_addr   = rd_addr_i;
  assign axi.ar_len    = 8'(rd_blen_i);
  assign axi.ar_size   = rd_size_i;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = rd_lock_i;
  assign axi.ar_cache  = 4'b0010;
  assign axi.ar_prot   = 3'b000;
  assign axi.ar_qos    = 4'b0000;
  assign axi.ar_region = 4'b0000;

  assign axi.r_ready   = rd_rdy_i;
  assign rd_valid_o    = axi.r_valid;
  assign rd_last_o     = axi.r_last;
  assign rd_data_o     = axi.r_data;
  assign rd_user_o     = axi.r_user;
  assign rd_id_o       = axi.r_id;
  assign rd_exokay_o   = (axi.r_resp == 2'b01);
  assign axi.b_ready   = wr_rdy_i;
  assign wr_valid_o    = axi.b_valid;
  assign wr_id_o       = axi.b_id;
  assign wr_exokay_o   = (axi.b_resp == 2'b01);

`ifdef AXI_SHIM_MO_PERF_CNT_EN
  logic wr_stall, rd_stall;
  assign wr_stall = (axi.aw_valid && !axi.aw_ready) || (axi.w_valid && !axi.w_ready)
                 || (wr_req_i && wr_busy_o);
  assign rd_stall = (axi.ar_valid && !axi.ar_ready) || (rd_req_i && rd_busy_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_stall_cnt_o <= '0;
      rd_stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      wr_stall_cnt_o <= '0;
      rd_stall_cnt_o <= '0;
    end else begin
      if (wr_stall && (wr_stall_cnt_o != '1)) wr_stall_cnt_o <= wr_stall_cnt_o + 32'd1;
      if (rd_stall && (rd_stall_cnt_o != '1)) rd_stall_cnt_o <= rd_stall_cnt_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_wr_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    b_hs |-> (wr_gnt_o || (wr_out_q != '0)));
  a_rd_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_last_hs |-> (rd_gnt_o || (rd_out_q != '0)));
  a_wr_blen_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_active |-> (int'(wr_blen_i) < int'(AxiNumWords)));
`endif
endmodule
